// File: rtl/imem_load_ctrl_pkg.sv
// rtl/imem_load_ctrl_pkg.sv - shared types and defaults for the instruction memory loader
package imem_load_ctrl_pkg;

  localparam int          IMEM_DEPTH_DEF = 16;
  localparam int          IMEM_AW_DEF    = 4;
  localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RUN    = 2'd3
  } load_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - assembles little-endian bytes into 32-bit words
module imem_byte_packer
  import imem_load_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_xfer,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word_data
);

  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] pack_q, pack_d;

  // Next byte lane and packed word; word_data is the word including the byte landing now
  always_comb begin
    bcnt_d    = bcnt_q;
    pack_d    = pack_q;
    word_done = 1'b0;
    if (clear) begin
      bcnt_d = 2'd0;
      pack_d = 32'd0;
    end else if (byte_xfer) begin
      pack_d[{bcnt_q, 3'b000} +: 8] = byte_data;
      bcnt_d    = bcnt_q + 2'd1;
      word_done = (bcnt_q == 2'd3);
    end
    word_data = pack_d;
  end

  // Lane counter and packing register
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= 2'd0;
      pack_q <= 32'd0;
    end else begin
      bcnt_q <= bcnt_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - loads a program into instruction memory, then releases the core
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH_DEF,
  parameter int          AW       = IMEM_AW_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          core_run,
  output logic          busy,
  output logic          fetch_fault
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

  load_state_e   state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic          fault_q, fault_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          start_ok;
  logic          byte_xfer;
  logic          word_done;
  logic [31:0]   word_data;
  logic          addr_ok;
  logic [AW:0]   wcnt_inc;

  assign start_ok  = load_start && (state_q == ST_IDLE || state_q == ST_RUN);
  assign byte_xfer = byte_valid && byte_ready;
  assign addr_ok   = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:AW+2] == '0);
  assign wcnt_inc  = wcnt_q + ONE_W;

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .byte_xfer (byte_xfer),
    .byte_data (byte_data),
    .word_done (word_done),
    .word_data (word_data)
  );

  // Moore-style outputs and the fetch mux; the core only sees memory while running
  always_comb begin
    byte_ready  = (state_q == ST_LOAD);
    core_run    = (state_q == ST_RUN);
    busy        = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
    mem_raddr   = fetch_addr[AW+1:2];
    fetch_instr = (core_run && addr_ok) ? mem_rdata : NOP_WORD;
    mem_we      = we_q;
    mem_waddr   = waddr_q;
    mem_wdata   = wdata_q;
    fetch_fault = fault_q;
  end

  // Next-state logic: a write is staged on the fourth byte and issued during COMMIT
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    fault_d = fault_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (state_q == ST_RUN && !addr_ok) begin
      fault_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start_ok) begin
          len_d   = (load_len > DEPTH_W) ? DEPTH_W : load_len;
          wcnt_d  = '0;
          fault_d = 1'b0;
          state_d = (load_len == '0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (word_done) begin
          state_d = ST_COMMIT;
          we_d    = 1'b1;
          waddr_d = wcnt_q[AW-1:0];
          wdata_d = word_data;
        end
      end
      ST_COMMIT: begin
        wcnt_d  = wcnt_inc;
        state_d = (wcnt_inc == len_q) ? ST_RUN : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      fault_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      fault_q <= fault_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;

  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_instr;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_run;
  logic          busy;
  logic          fetch_fault;

  logic [31:0] mem [DEPTH];
  logic [7:0]  bytes [64];
  int          wr_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_len    (load_len),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .core_run    (core_run),
    .busy        (busy),
    .fetch_fault (fetch_fault)
  );

  assign mem_rdata = mem[mem_raddr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    load_start = 1'b1;
    load_len   = (AW + 1)'(len);
    step();
    load_start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    int   sent = 0;
    int   cyc  = 0;
    logic rdy;
    logic vld;
    while (sent < n && cyc < 400) begin
      byte_valid = gaps ? (cyc % 3 != 2) : 1'b1;
      byte_data  = bytes[sent];
      #1;
      rdy = byte_ready;
      vld = byte_valid;
      if (mem_we) check("ready_in_commit", {31'd0, byte_ready}, 32'd0);
      step();
      if (rdy && vld) sent++;
      cyc++;
    end
    byte_valid = 1'b0;
    check("bytes_sent", sent, n);
  endtask

  task automatic wait_run();
    int cyc = 0;
    while (!core_run && cyc < 50) begin
      step();
      cyc++;
    end
    check("run_reached", {31'd0, core_run}, 32'd1);
  endtask

  initial begin
    int base_wr;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_0000 | i;
    rst = 1'b1; load_start = 1'b0; load_len = '0;
    byte_valid = 1'b0; byte_data = 8'h00; fetch_addr = 32'h0;
    step();
    step();
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_core_run", {31'd0, core_run}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fetch_instr", fetch_instr, NOP);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    rst = 1'b0;
    step();

    // two-word program, continuous byte stream
    {bytes[0], bytes[1], bytes[2], bytes[3]} = {8'h93, 8'h00, 8'h50, 8'h00};
    {bytes[4], bytes[5], bytes[6], bytes[7]} = {8'h13, 8'h01, 8'h50, 8'h00};
    start(2);
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_core_run", {31'd0, core_run}, 32'd0);
    check("load_ready", {31'd0, byte_ready}, 32'd1);
    check("load_fetch_nop", fetch_instr, NOP);
    feed(8, 1'b0);
    check("c2_we", {31'd0, mem_we}, 32'd1);
    check("c2_ready", {31'd0, byte_ready}, 32'd0);
    check("c2_waddr", {28'd0, mem_waddr}, 32'd1);
    check("c2_wdata", mem_wdata, 32'h0050_0113);
    step();
    check("p1_core_run", {31'd0, core_run}, 32'd1);
    check("p1_busy", {31'd0, busy}, 32'd0);
    check("p1_writes", wr_cnt, 2);
    check("p1_mem0", mem[0], 32'h0050_0093);
    fetch_addr = 32'h4;
    #1;
    check("p1_fetch4", fetch_instr, 32'h0050_0113);
    fetch_addr = 32'h0;
    #1;
    check("p1_fetch0", fetch_instr, 32'h0050_0093);

    // out-of-range fetch, then zero-length load clears the fault
    fetch_addr = 32'h40;
    #1;
    check("oor_nop", fetch_instr, NOP);
    step();
    check("oor_fault", {31'd0, fetch_fault}, 32'd1);
    fetch_addr = 32'h0;
    start(0);
    check("len0_fault_clr", {31'd0, fetch_fault}, 32'd0);
    check("len0_core_run", {31'd0, core_run}, 32'd1);
    check("len0_writes", wr_cnt, 2);
    fetch_addr = 32'h1;
    #1;
    check("mis_nop", fetch_instr, NOP);
    step();
    check("mis_fault", {31'd0, fetch_fault}, 32'd1);
    step();
    check("mis_sticky", {31'd0, fetch_fault}, 32'd1);
    fetch_addr = 32'h0;

    // oversize length clamps to DEPTH, stream with gaps, reload from RUN
    for (int i = 0; i < 64; i++) bytes[i] = 8'(i + 8'h10);
    start(20);
    check("big_core_run", {31'd0, core_run}, 32'd0);
    check("big_fault", {31'd0, fetch_fault}, 32'd0);
    feed(64, 1'b1);
    wait_run();
    check("big_writes", wr_cnt, 18);
    check("big_mem0", mem[0], 32'h1312_1110);
    check("big_mem15", mem[15], 32'h4F4E_4D4C);

    // short reload keeps later words
    {bytes[0], bytes[1], bytes[2], bytes[3]} = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    start(1);
    feed(4, 1'b0);
    wait_run();
    check("short_writes", wr_cnt, 19);
    fetch_addr = 32'h0;
    #1;
    check("short_fetch0", fetch_instr, 32'hAABB_CCDD);
    fetch_addr = 32'h4;
    #1;
    check("short_fetch4", fetch_instr, 32'h1716_1514);
    fetch_addr = 32'h0;

    // reset in the middle of a word discards the partial bytes
    base_wr = wr_cnt;
    {bytes[0], bytes[1], bytes[2]} = {8'hEE, 8'hEE, 8'hEE};
    start(2);
    feed(3, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_core_run", {31'd0, core_run}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ready", {31'd0, byte_ready}, 32'd0);
    step();
    step();
    check("mrst_no_write", wr_cnt, base_wr);
    {bytes[0], bytes[1], bytes[2], bytes[3]} = {8'h11, 8'h22, 8'h33, 8'h44};
    start(1);
    feed(4, 1'b0);
    check("mrst_wdata", mem_wdata, 32'h4433_2211);
    check("mrst_waddr", {28'd0, mem_waddr}, 32'd0);
    wait_run();
    check("mrst_writes", wr_cnt, base_wr + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
